// File: rtl/mistral_mul54_seq_if.sv
// Operand/product handshake bundle for the sequential 54x54 multiplier.
// The slave side is the multiplier; the master side supplies operands and consumes Y.
interface mistral_mul54_seq_if #(
   parameter int A_WIDTH = 54,
   parameter int B_WIDTH = 54
);
   logic                       IN_VALID;
   logic                       IN_READY;
   logic [A_WIDTH-1:0]         A;
   logic [B_WIDTH-1:0]         B;
   logic                       OUT_VALID;
   logic                       OUT_READY;
   logic [A_WIDTH+B_WIDTH-1:0] Y;

   modport slave  (input  IN_VALID, A, B, OUT_READY,
                   output IN_READY, OUT_VALID, Y);
   modport master (output IN_VALID, A, B, OUT_READY,
                   input  IN_READY, OUT_VALID, Y);
endinterface

// File: rtl/mistral_mul54_seq.sv
// Unsigned up-to-54x54 multiplier built from four passes through one 27x27 multiplier,
// accumulating shifted partial products into a 108-bit accumulator.
module mistral_mul54_seq #(
   parameter int A_WIDTH = 54,
   parameter int B_WIDTH = 54
) (
   input  logic CLK,
   input  logic ACLR,
   mistral_mul54_seq_if.slave bus
);

   typedef enum logic [1:0] {INIT, IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [2:0]    s_q;
   logic [53:0]   a_q, b_q;
   logic [26:0]   ma_q, mb_q, ma_d, mb_d;
   logic [53:0]   pp;
   logic [107:0]  pp_sh;
   logic [107:0]  acc_q;
   logic          accept;

   assign accept = (state_q == IDLE) && bus.IN_VALID;

   // INIT holds IN_READY low for the first edge after reset release.
   always_ff @(posedge CLK or negedge ACLR) begin
      if (!ACLR) state_q <= INIT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    state_d = IDLE;
         IDLE:    if (bus.IN_VALID)  state_d = RUN;
         RUN:     if (s_q == 3'd4)   state_d = DONE;
         DONE:    if (bus.OUT_READY) state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   // Operand slice pair for step S.
   always_comb begin
      ma_d = a_q[26:0];
      mb_d = b_q[26:0];
      case (s_q)
         3'd1: mb_d = b_q[53:27];
         3'd2: ma_d = a_q[53:27];
         3'd3: begin ma_d = a_q[53:27]; mb_d = b_q[53:27]; end
         default: ;
      endcase
   end

   assign pp = {27'b0, ma_q} * {27'b0, mb_q};

   // Shift of the product returned this cycle belongs to the pair loaded at S-1.
   always_comb begin
      case (s_q)
         3'd1:       pp_sh = {54'b0, pp};
         3'd2, 3'd3: pp_sh = {27'b0, pp, 27'b0};
         default:    pp_sh = {pp, 54'b0};
      endcase
   end

   always_ff @(posedge CLK or negedge ACLR) begin
      if (!ACLR) begin
         a_q   <= '0;
         b_q   <= '0;
         ma_q  <= '0;
         mb_q  <= '0;
         acc_q <= '0;
         s_q   <= '0;
      end else if (accept) begin
         a_q   <= 54'(bus.A);
         b_q   <= 54'(bus.B);
         acc_q <= '0;
         s_q   <= '0;
      end else if (state_q == RUN) begin
         if (s_q < 3'd4) begin
            ma_q <= ma_d;
            mb_q <= mb_d;
         end
         if (s_q != 3'd0) acc_q <= acc_q + pp_sh;
         s_q <= s_q + 3'd1;
      end
   end

   assign bus.IN_READY  = (state_q == IDLE);
   assign bus.OUT_VALID = (state_q == DONE);
   assign bus.Y         = acc_q[A_WIDTH+B_WIDTH-1:0];

endmodule

// File: tb/tb_mistral_mul54_seq.sv
// Scoreboard bench: drivers push expected products, monitors check them when OUT_VALID rises.
module tb_mistral_mul54_seq;

   typedef struct {
      logic [107:0] y;
      int           due;
   } exp_t;

   logic clk = 1'b0;
   logic aclr = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   exp_t qm[$];
   exp_t qn[$];

   mistral_mul54_seq_if #(.A_WIDTH(54), .B_WIDTH(54)) m();
   mistral_mul54_seq_if #(.A_WIDTH(18), .B_WIDTH(9))  n();

   mistral_mul54_seq #(.A_WIDTH(54), .B_WIDTH(54)) dut_w (.CLK(clk), .ACLR(aclr), .bus(m));
   mistral_mul54_seq #(.A_WIDTH(18), .B_WIDTH(9))  dut_n (.CLK(clk), .ACLR(aclr), .bus(n));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitors: compare value and latency on the rising OUT_VALID, then demand stability.
   logic         mv_prev = 1'b0, nv_prev = 1'b0;
   logic [107:0] m_held, n_held;
   exp_t         me, ne;

   always @(negedge clk) begin
      if (m.OUT_VALID && !mv_prev) begin
         if (qm.size() == 0) chk("main_unexpected_out", 108'd1, 108'd0);
         else begin
            me = qm.pop_front();
            chk("main_y", m.Y, me.y);
            chk("main_latency", 108'(cyc), 108'(me.due));
         end
         m_held = m.Y;
      end else if (m.OUT_VALID) begin
         chk("main_y_stable", m.Y, m_held);
      end
      mv_prev = m.OUT_VALID;
   end

   always @(negedge clk) begin
      if (n.OUT_VALID && !nv_prev) begin
         if (qn.size() == 0) chk("narrow_unexpected_out", 108'd1, 108'd0);
         else begin
            ne = qn.pop_front();
            chk("narrow_y", 108'(n.Y), ne.y);
            chk("narrow_latency", 108'(cyc), 108'(ne.due));
         end
      end
      nv_prev = n.OUT_VALID;
   end

   task automatic wait_ready_m();
      int k = 0;
      while (!m.IN_READY && k < 50) begin @(negedge clk); k++; end
      if (!m.IN_READY) chk("main_ready_timeout", 108'd0, 108'd1);
   endtask

   // One operation on the wide DUT; hold>0 stalls OUT_READY and wiggles IN_VALID.
   task automatic run_op(input logic [53:0] a, input logic [53:0] b,
                         input logic [107:0] ey, input int hold);
      int k = 0;
      wait_ready_m();
      m.OUT_READY = (hold == 0);
      m.A = a; m.B = b; m.IN_VALID = 1'b1;
      @(posedge clk); #1;
      qm.push_back('{y: ey, due: cyc + 5});
      @(negedge clk);
      m.IN_VALID = 1'b0;
      while (!m.OUT_VALID && k < 20) begin
         chk("main_inready_busy", 108'(m.IN_READY), 108'd0);
         @(negedge clk); k++;
      end
      if (!m.OUT_VALID) chk("main_out_timeout", 108'd0, 108'd1);
      for (int i = 0; i < hold; i++) begin
         chk("bp_out_valid", 108'(m.OUT_VALID), 108'd1);
         chk("bp_in_ready", 108'(m.IN_READY), 108'd0);
         m.IN_VALID = ~m.IN_VALID;
         m.A = 54'(i * 1234567 + 17);
         m.B = 54'(i * 7654321 + 3);
         @(negedge clk);
      end
      m.IN_VALID = 1'b0;
      m.OUT_READY = 1'b1;
      @(negedge clk);
      chk("main_out_valid_drop", 108'(m.OUT_VALID), 108'd0);
      chk("main_in_ready_rise", 108'(m.IN_READY), 108'd1);
   endtask

   initial begin
      int k;
      m.IN_VALID = 1'b0; m.A = '0; m.B = '0; m.OUT_READY = 1'b1;
      n.IN_VALID = 1'b0; n.A = '0; n.B = '0; n.OUT_READY = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 108'(m.IN_READY), 108'd0);
      chk("rst_out_valid", 108'(m.OUT_VALID), 108'd0);
      chk("rst_y", m.Y, 108'd0);
      chk("rst_narrow_y", 108'(n.Y), 108'd0);
      aclr = 1'b1;
      #1 chk("rel_in_ready_low", 108'(m.IN_READY), 108'd0);
      @(negedge clk);
      chk("rel_in_ready_rise", 108'(m.IN_READY), 108'd1);

      run_op(54'd3, 54'd5, 108'd15, 0);
      run_op(54'd1 << 27, 54'd1 << 27, 108'd1 << 54, 0);
      run_op(54'd1 << 27, 54'd1, 108'd1 << 27, 0);
      run_op({54{1'b1}}, {54{1'b1}}, 108'hFFFF_FFFF_FFFF_F800_0000_0000_001, 0);
      run_op(54'd123456789, 54'd1000, 108'd123456789000, 10);

      // Mid-run reset at S=2: the in-flight product must vanish.
      wait_ready_m();
      m.A = 54'd11; m.B = 54'd13; m.IN_VALID = 1'b1;
      @(posedge clk);
      @(negedge clk); m.IN_VALID = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      aclr = 1'b0;
      #1;
      chk("midrst_out_valid", 108'(m.OUT_VALID), 108'd0);
      chk("midrst_y", m.Y, 108'd0);
      chk("midrst_in_ready", 108'(m.IN_READY), 108'd0);
      @(negedge clk);
      aclr = 1'b1;
      @(negedge clk);
      chk("midrst_ready_after_release", 108'(m.IN_READY), 108'd1);
      run_op(54'd7, 54'd9, 108'd63, 0);

      // Narrow instance.
      k = 0;
      while (!n.IN_READY && k < 50) begin @(negedge clk); k++; end
      n.A = 18'h3FFFF; n.B = 9'h1FF; n.IN_VALID = 1'b1;
      @(posedge clk); #1;
      qn.push_back('{y: 108'd133955073, due: cyc + 5});
      @(negedge clk);
      n.IN_VALID = 1'b0;
      k = 0;
      while (!n.OUT_VALID && k < 20) begin @(negedge clk); k++; end
      if (!n.OUT_VALID) chk("narrow_out_timeout", 108'd0, 108'd1);

      repeat (4) @(negedge clk);
      chk("main_queue_drained", 108'(qm.size()), 108'd0);
      chk("narrow_queue_drained", 108'(qn.size()), 108'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
